// File: rtl/bus_mux2_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Purpose  : Shared encodings and the arbitration rule for bus_mux2_arbiter.
//            Holds the FSM state type, the mux select constants and a pure
//            function that picks the next grant from the current valids.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Packet-level arbitration decision. On a tie the requester that was not
  // granted last wins, unless fixed priority forces A.
  function automatic state_t arbitrate(input logic a_valid,
                                       input logic b_valid,
                                       input logic last_grant,
                                       input logic fixed_prio);
    state_t result;
    if (a_valid && b_valid) begin
      result = (fixed_prio || (last_grant == SEL_B)) ? GRANT_A : GRANT_B;
    end else if (a_valid) begin
      result = GRANT_A;
    end else if (b_valid) begin
      result = GRANT_B;
    end else begin
      result = IDLE;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_mux2_arbiter_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : out_stage_reg
// Purpose  : Single-entry valid/ready pipeline register driving the
//            downstream consumer. Reports when it can take a new beat.
// Ports    : clk, rst_n         - clock, async active-low reset
//            load, load_data    - write a new beat (only when slot_free)
//            out_ready          - downstream accepts the held beat
//            out_valid, out_q   - held beat
//            slot_free          - register empty or draining this cycle
// Revision : 1.0 - initial release
// ============================================================================
module out_stage_reg #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_q,
  output logic              slot_free
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_q     <= load_data;
    end else if (out_ready) begin
      // Data is left in place; only the valid flag retires.
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_mux2_arbiter
// Purpose  : Shares one 2:1 data mux between two packet streams (A, B).
//            Round-robin (or A-priority) arbitration at packet granularity;
//            the winner keeps the mux until its last beat is accepted.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            a_valid/a_data/a_last/a_ready   - requester A stream
//            b_valid/b_data/b_last/b_ready   - requester B stream
//            sel                             - registered mux select (0=A)
//            out_valid/out_data/out_last     - registered output beat
//            out_ready                       - downstream ready
// Revision : 1.0 - initial release
// ============================================================================
module bus_mux2_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  state_t           state;
  state_t           next_state;
  state_t           arb;
  logic             last_grant;
  logic             rearb;
  logic             xfer;
  logic             slot_free;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;
  logic [WIDTH:0]   stage_q;

  assign arb = arbitrate(a_valid, b_valid, last_grant, FIXED_PRIO);

  always_comb begin
    next_state = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    xfer       = 1'b0;
    rearb      = 1'b0;
    case (state)
      IDLE: begin
        rearb      = 1'b1;
        next_state = arb;
      end
      GRANT_A: begin
        a_ready = slot_free;
        xfer    = a_valid && slot_free;
        // Last beat hands the mux straight to the next winner, no bubble.
        if (xfer && a_last) begin
          rearb      = 1'b1;
          next_state = arb;
        end
      end
      GRANT_B: begin
        b_ready = slot_free;
        xfer    = b_valid && slot_free;
        if (xfer && b_last) begin
          rearb      = 1'b1;
          next_state = arb;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // sel and the round-robin pointer move together, only on a grant edge.
  // Reset points last_grant at B so the first tie goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= SEL_A;
      last_grant <= SEL_B;
    end else if (rearb && (arb != IDLE)) begin
      sel        <= (arb == GRANT_B) ? SEL_B : SEL_A;
      last_grant <= (arb == GRANT_B) ? SEL_B : SEL_A;
    end
  end

  assign mux_data = (a_data & ~{WIDTH{sel}}) | (b_data & {WIDTH{sel}});
  assign mux_last = (a_last & ~sel) | (b_last & sel);

  out_stage_reg #(
    .DATA_W (WIDTH + 1)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (xfer),
    .load_data ({mux_last, mux_data}),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_q     (stage_q),
    .slot_free (slot_free)
  );

  assign out_data = stage_q[WIDTH-1:0];
  assign out_last = stage_q[WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_bus_mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mux2_arbiter
// Purpose  : Directed self-checking bench for bus_mux2_arbiter. A second
//            instance with FIXED_PRIO=1 shares the inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mux2_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_last, b_valid, b_last, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, sel, out_valid, out_last;
  logic [7:0] out_data;
  logic       fp_a_ready, fp_b_ready, fp_sel, fp_out_valid, fp_out_last;
  logic [7:0] fp_out_data;

  int checks = 0;
  int errors = 0;

  bus_mux2_arbiter #(.WIDTH(8), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  bus_mux2_arbiter #(.WIDTH(8), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(fp_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(fp_b_ready),
    .sel(fp_sel), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_last(fp_out_last), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_last = 1'b0; a_data = 8'h00;
    b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // ---------------- 1: reset with both requesting -------------------
    rst_n = 1'b0;
    idle_inputs();
    a_valid = 1'b1; a_data = 8'h5A;
    b_valid = 1'b1; b_data = 8'h6B;
    #1;
    chk("t1_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_rst_out_data",  {24'd0, out_data},  32'd0);
    chk("t1_rst_out_last",  {31'd0, out_last},  32'd0);
    chk("t1_rst_sel",       {31'd0, sel},       32'd0);
    chk("t1_rst_a_ready",   {31'd0, a_ready},   32'd0);
    chk("t1_rst_b_ready",   {31'd0, b_ready},   32'd0);
    step();
    step();
    chk("t1_rst_held_a_ready", {31'd0, a_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_idle_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    chk("t1_grant_a_ready", {31'd0, a_ready},   32'd1);
    chk("t1_grant_b_ready", {31'd0, b_ready},   32'd0);
    chk("t1_grant_sel",     {31'd0, sel},       32'd0);
    chk("t1_no_beat_yet",   {31'd0, out_valid}, 32'd0);

    // ---------------- 2: B alone, 3 beats -----------------------------
    do_reset();
    b_valid = 1'b1; b_data = 8'h11;
    step();
    chk("t2_sel", {31'd0, sel}, 32'd1);
    chk("t2_b_ready", {31'd0, b_ready}, 32'd1);
    chk("t2_a_ready", {31'd0, a_ready}, 32'd0);
    chk("t2_no_beat", {31'd0, out_valid}, 32'd0);
    step();
    b_data = 8'h22;
    chk("t2_beat1_data", {24'd0, out_data}, 32'h11);
    chk("t2_beat1_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_beat1_last", {31'd0, out_last}, 32'd0);
    step();
    b_data = 8'h33; b_last = 1'b1;
    chk("t2_beat2_data", {24'd0, out_data}, 32'h22);
    chk("t2_beat2_last", {31'd0, out_last}, 32'd0);
    step();
    b_valid = 1'b0; b_last = 1'b0;
    chk("t2_beat3_data", {24'd0, out_data}, 32'h33);
    chk("t2_beat3_last", {31'd0, out_last}, 32'd1);
    chk("t2_beat3_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("t2_drained", {31'd0, out_valid}, 32'd0);

    // ---------------- 3: single-beat packets, both requesting ---------
    do_reset();
    a_valid = 1'b1; a_last = 1'b1; a_data = 8'hA0;
    b_valid = 1'b1; b_last = 1'b1; b_data = 8'hB0;
    step();
    chk("t3_first_sel", {31'd0, sel}, 32'd0);
    step();
    a_data = 8'hA1;
    chk("t3_out0", {24'd0, out_data}, 32'hA0);
    chk("t3_sel0", {31'd0, sel}, 32'd1);
    chk("t3_fp_out0", {24'd0, fp_out_data}, 32'hA0);
    step();
    b_data = 8'hB1;
    chk("t3_out1", {24'd0, out_data}, 32'hB0);
    chk("t3_valid1", {31'd0, out_valid}, 32'd1);
    chk("t3_sel1", {31'd0, sel}, 32'd0);
    chk("t3_fp_out1", {24'd0, fp_out_data}, 32'hA1);
    step();
    a_data = 8'hA2;
    chk("t3_out2", {24'd0, out_data}, 32'hA1);
    chk("t3_last2", {31'd0, out_last}, 32'd1);
    chk("t3_fp_out2", {24'd0, fp_out_data}, 32'hA1);
    chk("t3_fp_sel2", {31'd0, fp_sel}, 32'd0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_out3", {24'd0, out_data}, 32'hB1);
    chk("t3_valid3", {31'd0, out_valid}, 32'd1);
    chk("t3_fp_out3", {24'd0, fp_out_data}, 32'hA2);
    chk("t3_fp_b_ready", {31'd0, fp_b_ready}, 32'd0);

    // ---------------- 4: packet lock while A stalls --------------------
    do_reset();
    a_valid = 1'b1; a_data = 8'h01;
    b_valid = 1'b1; b_data = 8'hC1; b_last = 1'b1;
    step();
    chk("t4_a_ready", {31'd0, a_ready}, 32'd1);
    chk("t4_b_ready0", {31'd0, b_ready}, 32'd0);
    step();
    a_data = 8'h02;
    chk("t4_beat1", {24'd0, out_data}, 32'h01);
    step();
    a_valid = 1'b0;
    #1;
    chk("t4_beat2", {24'd0, out_data}, 32'h02);
    chk("t4_b_ready1", {31'd0, b_ready}, 32'd0);
    step();
    chk("t4_gap_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_gap_b_ready", {31'd0, b_ready}, 32'd0);
    chk("t4_gap_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b1; a_data = 8'h03;
    #1;
    chk("t4_gap2_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    a_data = 8'h04; a_last = 1'b1;
    chk("t4_beat3", {24'd0, out_data}, 32'h03);
    chk("t4_beat3_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    a_valid = 1'b0; a_last = 1'b0;
    #1;
    chk("t4_beat4", {24'd0, out_data}, 32'h04);
    chk("t4_beat4_last", {31'd0, out_last}, 32'd1);
    chk("t4_b_granted", {31'd0, b_ready}, 32'd1);
    chk("t4_a_off", {31'd0, a_ready}, 32'd0);
    chk("t4_sel_b", {31'd0, sel}, 32'd1);
    step();
    b_valid = 1'b0; b_last = 1'b0;
    chk("t4_b_beat", {24'd0, out_data}, 32'hC1);

    // ---------------- 5: downstream backpressure ----------------------
    do_reset();
    a_valid = 1'b1; a_data = 8'h41;
    step();
    step();
    a_data = 8'h42; out_ready = 1'b0;
    #1;
    chk("t5_bp0_data", {24'd0, out_data}, 32'h41);
    chk("t5_bp0_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    chk("t5_bp1_data", {24'd0, out_data}, 32'h41);
    chk("t5_bp1_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_bp1_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    chk("t5_bp2_data", {24'd0, out_data}, 32'h41);
    step();
    chk("t5_bp3_data", {24'd0, out_data}, 32'h41);
    chk("t5_bp3_last", {31'd0, out_last}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("t5_resume_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_data = 8'h43; a_last = 1'b1;
    chk("t5_next_data", {24'd0, out_data}, 32'h42);
    chk("t5_next_valid", {31'd0, out_valid}, 32'd1);
    step();
    a_valid = 1'b0; a_last = 1'b0;
    chk("t5_final_data", {24'd0, out_data}, 32'h43);
    chk("t5_final_last", {31'd0, out_last}, 32'd1);
    step();
    chk("t5_drained", {31'd0, out_valid}, 32'd0);

    // ---------------- 6: reset mid-packet ------------------------------
    do_reset();
    a_valid = 1'b1; a_data = 8'h61;
    b_valid = 1'b1; b_data = 8'hD1; b_last = 1'b1;
    step();
    step();
    a_data = 8'h62;
    step();
    chk("t6_beat2", {24'd0, out_data}, 32'h62);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_data", {24'd0, out_data}, 32'd0);
    chk("t6_rst_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_idle_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    chk("t6_regrant_a", {31'd0, a_ready}, 32'd1);
    chk("t6_regrant_b_off", {31'd0, b_ready}, 32'd0);
    chk("t6_regrant_sel", {31'd0, sel}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
